// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the pipeline hazard controller.
//   FWD_*     : E-stage operand select codes (regfile / W result / M ALU result)
//   state_e   : sequencing FSM states (ST_RUN, ST_MDU_WAIT)
//   ZERO_WORD : 32-bit zero used to clear the optional performance counters
//   reg_match : true when a source register equals a destination and is not r0
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // r0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: combinational forwarding select for one E-stage operand.
//   src_i                         : source register of the operand in E
//   write_reg_m_i, reg_write_m_i  : destination / write enable of the instruction in M
//   write_reg_w_i, reg_write_w_i  : destination / write enable of the instruction in W
//   sel_o                         : FWD_M, FWD_W or FWD_REG (M has priority, being younger)
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] write_reg_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] write_reg_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (reg_write_m_i && reg_match(src_i, write_reg_m_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && reg_match(src_i, write_reg_w_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Produces stall/flush/forward controls for the F/D/E/M stage registers, detects load-use and
// branch-operand hazards, and holds the pipeline during multi-cycle MDU operations with a
// timeout watchdog.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   rsD/rtD, rsE/rtE               : source registers of the instructions in D and E
//   writeReg{E,M,W}, regWrite{E,M,W}: destination and write enable per stage
//   memToRegE/M                    : load in E / M
//   branchD                        : branch/compare in D
//   mduStartE, mduDone             : MDU start / result-valid pulses
//   stallF/D/E, flushE, flushM     : stage register hold / bubble controls
//   forwardAE/BE, forwardAD/BD     : operand forwarding selects
//   mduBusy, mduErr                : MDU wait in progress / timeout pulse
// Optional build macro HAZARD_PERF_EN adds saturating 32-bit stall counters
// lwStallCnt, brStallCnt and mduStallCnt.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeRegE,
  input  logic [4:0]  writeRegM,
  input  logic [4:0]  writeRegW,
  input  logic        regWriteE,
  input  logic        regWriteM,
  input  logic        regWriteW,
  input  logic        memToRegE,
  input  logic        memToRegM,
  input  logic        branchD,
  input  logic        mduStartE,
  input  logic        mduDone,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushE,
  output logic        flushM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic        mduBusy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] lwStallCnt,
  output logic [31:0] brStallCnt,
  output logic [31:0] mduStallCnt,
`endif
  output logic        mduErr
);

  localparam logic [TO_W-1:0] ToLast = TO_W'(MDU_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        fwd_ae, fwd_be;
  logic              lw_stall, br_stall;

  hazard_ctrl_fwd_sel u_fwd_a (
    .src_i         (rsE),
    .write_reg_m_i (writeRegM),
    .reg_write_m_i (regWriteM),
    .write_reg_w_i (writeRegW),
    .reg_write_w_i (regWriteW),
    .sel_o         (fwd_ae)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .src_i         (rtE),
    .write_reg_m_i (writeRegM),
    .reg_write_m_i (regWriteM),
    .write_reg_w_i (writeRegW),
    .reg_write_w_i (regWriteW),
    .sel_o         (fwd_be)
  );

  always_comb begin
    lw_stall = memToRegE && ((rtE == rsD) || (rtE == rtD));
    br_stall = branchD &&
               ((regWriteE && (reg_match(rsD, writeRegE) || reg_match(rtD, writeRegE))) ||
                (memToRegM && (reg_match(rsD, writeRegM) || reg_match(rtD, writeRegM))));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    mduBusy   = 1'b0;
    mduErr    = 1'b0;
    forwardAE = fwd_ae;
    forwardBE = fwd_be;
    forwardAD = regWriteM && reg_match(rsD, writeRegM);
    forwardBD = regWriteM && reg_match(rtD, writeRegM);
    unique case (state_q)
      ST_RUN: begin
        stallF = lw_stall | br_stall;
        stallD = lw_stall | br_stall;
        flushE = lw_stall | br_stall;
        if (mduStartE) begin
          state_d = ST_MDU_WAIT;
          cnt_d   = '0;
        end
      end
      ST_MDU_WAIT: begin
        // Hazards from D are masked here; E is held, so no bubble goes into ID/EX.
        mduBusy = 1'b1;
        cnt_d   = cnt_q + TO_W'(1);
        if (mduDone) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == ToLast) begin
          mduErr  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end
      end
    endcase
    // All controls drop immediately while reset is applied, not just at the next edge.
    if (rst) begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      mduBusy   = 1'b0;
      mduErr    = 1'b0;
      forwardAE = FWD_REG;
      forwardBE = FWD_REG;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] lw_cnt_q, lw_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mdu_cnt_q, mdu_cnt_d;

  always_comb begin
    lw_cnt_d  = lw_cnt_q;
    br_cnt_d  = br_cnt_q;
    mdu_cnt_d = mdu_cnt_q;
    // Counters saturate rather than wrap.
    if ((state_q == ST_RUN) && lw_stall && (lw_cnt_q != 32'hFFFF_FFFF)) begin
      lw_cnt_d = lw_cnt_q + 32'd1;
    end
    if ((state_q == ST_RUN) && br_stall && !lw_stall && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if ((state_q == ST_MDU_WAIT) && !mduDone && (mdu_cnt_q != 32'hFFFF_FFFF)) begin
      mdu_cnt_d = mdu_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_cnt_q  <= ZERO_WORD;
      br_cnt_q  <= ZERO_WORD;
      mdu_cnt_q <= ZERO_WORD;
    end else begin
      lw_cnt_q  <= lw_cnt_d;
      br_cnt_q  <= br_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign lwStallCnt  = lw_cnt_q;
  assign brStallCnt  = br_cnt_q;
  assign mduStallCnt = mdu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MDU_TIMEOUT=16).
// ctl packs {stallF, stallD, stallE, flushE, flushM, mduBusy, mduErr};
// fwd packs {forwardAE, forwardBE, forwardAD, forwardBD}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD;
  logic       mduStartE, mduDone;
  logic       stallF, stallD, stallE, flushE, flushM, forwardAD, forwardBD, mduBusy, mduErr;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] lwStallCnt, brStallCnt, mduStallCnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [6:0] ctl;
  logic [5:0] fwd;
  assign ctl = {stallF, stallD, stallE, flushE, flushM, mduBusy, mduErr};
  assign fwd = {forwardAE, forwardBE, forwardAD, forwardBD};

  localparam logic [6:0] CtlIdle = 7'b000_0000;
  localparam logic [6:0] CtlHaz  = 7'b110_1000;
  localparam logic [6:0] CtlWait = 7'b111_0110;
  localparam logic [6:0] CtlDone = 7'b000_0010;
  localparam logic [6:0] CtlErr  = 7'b000_0011;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MDU_TIMEOUT (16),
    .TO_W        (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rsD         (rsD),
    .rtD         (rtD),
    .rsE         (rsE),
    .rtE         (rtE),
    .writeRegE   (writeRegE),
    .writeRegM   (writeRegM),
    .writeRegW   (writeRegW),
    .regWriteE   (regWriteE),
    .regWriteM   (regWriteM),
    .regWriteW   (regWriteW),
    .memToRegE   (memToRegE),
    .memToRegM   (memToRegM),
    .branchD     (branchD),
    .mduStartE   (mduStartE),
    .mduDone     (mduDone),
    .stallF      (stallF),
    .stallD      (stallD),
    .stallE      (stallE),
    .flushE      (flushE),
    .flushM      (flushM),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .forwardAD   (forwardAD),
    .forwardBD   (forwardBD),
    .mduBusy     (mduBusy),
`ifdef HAZARD_PERF_EN
    .lwStallCnt  (lwStallCnt),
    .brStallCnt  (brStallCnt),
    .mduStallCnt (mduStallCnt),
`endif
    .mduErr      (mduErr)
  );

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0;
    memToRegE = 0; memToRegM = 0; branchD = 0;
    mduStartE = 0; mduDone = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1; memToRegE = 1'b1;
    #2;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CtlIdle);
    end
    checks++;
    if (fwd !== 6'b0) begin
      failures++; $display("FAIL reset_fwd got=%b exp=%b", fwd, 6'b0);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({lwStallCnt, brStallCnt, mduStallCnt} !== 96'd0) begin
      failures++; $display("FAIL reset_perf got=%0h/%0h/%0h exp=0", lwStallCnt, brStallCnt,
                           mduStallCnt);
    end
`endif
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    // Reset in the middle of an MDU wait (counter at 10).
    mduStartE = 1'b1;
    cyc();
    mduStartE = 1'b0;
    repeat (10) cyc();
    checks++;
    if (ctl !== CtlWait) begin
      failures++; $display("FAIL reset_prewait got=%b exp=%b", ctl, CtlWait);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL reset_async_drop got=%b exp=%b", ctl, CtlIdle);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL reset_run_after got=%b exp=%b", ctl, CtlIdle);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1; writeRegW = 5'd3; regWriteW = 1'b1;
    rtE = 5'd4;
    #1;
    checks++;
    if (fwd !== 6'b10_00_0_0) begin
      failures++; $display("FAIL fwd_m_prio got=%b exp=%b", fwd, 6'b10_00_0_0);
    end
    writeRegM = 5'd0;
    #1;
    checks++;
    if (fwd !== 6'b01_00_0_0) begin
      failures++; $display("FAIL fwd_w got=%b exp=%b", fwd, 6'b01_00_0_0);
    end
    rsE = 5'd0; writeRegW = 5'd0;
    #1;
    checks++;
    if (fwd !== 6'b00_00_0_0) begin
      failures++; $display("FAIL fwd_r0 got=%b exp=%b", fwd, 6'b00_00_0_0);
    end
    rtE = 5'd9; writeRegM = 5'd9; writeRegW = 5'd9; rsD = 5'd9; rtD = 5'd2;
    #1;
    checks++;
    if (fwd !== 6'b00_10_1_0) begin
      failures++; $display("FAIL fwd_b_m_ad got=%b exp=%b", fwd, 6'b00_10_1_0);
    end
    regWriteM = 1'b0; rtD = 5'd9;
    #1;
    checks++;
    if (fwd !== 6'b00_01_0_0) begin
      failures++; $display("FAIL fwd_b_w got=%b exp=%b", fwd, 6'b00_01_0_0);
    end
    regWriteM = 1'b1; rsD = 5'd1;
    #1;
    checks++;
    if (fwd !== 6'b00_10_0_1) begin
      failures++; $display("FAIL fwd_bd got=%b exp=%b", fwd, 6'b00_10_0_1);
    end
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL fwd_no_stall got=%b exp=%b", ctl, CtlIdle);
    end
    cyc();
  endtask

  task automatic test_load_use();
`ifdef HAZARD_PERF_EN
    logic [31:0] lw0;
    lw0 = lwStallCnt;
`endif
    clear_inputs();
    memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; rtE = 5'd5; rsD = 5'd5;
    #1;
    checks++;
    if (ctl !== CtlHaz) begin
      failures++; $display("FAIL lw_stall got=%b exp=%b", ctl, CtlHaz);
    end
    cyc();
    // Load now in M, bubble in E, consumer still in D.
    clear_inputs();
    memToRegM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd5; rsD = 5'd5;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL lw_one_cycle got=%b exp=%b", ctl, CtlIdle);
    end
    checks++;
    if (fwd !== 6'b00_00_1_0) begin
      failures++; $display("FAIL lw_bubble_fwd got=%b exp=%b", fwd, 6'b00_00_1_0);
    end
    cyc();
    clear_inputs();
    rsE = 5'd5; regWriteW = 1'b1; writeRegW = 5'd5;
    #1;
    checks++;
    if (fwd !== 6'b01_00_0_0) begin
      failures++; $display("FAIL lw_w_fwd got=%b exp=%b", fwd, 6'b01_00_0_0);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (lwStallCnt - lw0 !== 32'd1) begin
      failures++; $display("FAIL lw_perf got=%0d exp=1", lwStallCnt - lw0);
    end
`endif
    cyc();
  endtask

  task automatic test_branch();
`ifdef HAZARD_PERF_EN
    logic [31:0] br0;
    br0 = brStallCnt;
`endif
    clear_inputs();
    branchD = 1'b1; rsD = 5'd7; regWriteE = 1'b1; writeRegE = 5'd7;
    #1;
    checks++;
    if (ctl !== CtlHaz) begin
      failures++; $display("FAIL br_e_stall got=%b exp=%b", ctl, CtlHaz);
    end
    cyc();
    regWriteE = 1'b0; writeRegE = 5'd0; regWriteM = 1'b1; writeRegM = 5'd7;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL br_release got=%b exp=%b", ctl, CtlIdle);
    end
    checks++;
    if (fwd !== 6'b00_00_1_0) begin
      failures++; $display("FAIL br_fwd_ad got=%b exp=%b", fwd, 6'b00_00_1_0);
    end
    cyc();
    rsD = 5'd0; rtD = 5'd7; memToRegM = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlHaz) begin
      failures++; $display("FAIL br_load_m_stall got=%b exp=%b", ctl, CtlHaz);
    end
    cyc();
    clear_inputs();
    branchD = 1'b1; regWriteE = 1'b1; writeRegE = 5'd0; memToRegM = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL br_r0 got=%b exp=%b", ctl, CtlIdle);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (brStallCnt - br0 !== 32'd2) begin
      failures++; $display("FAIL br_perf got=%0d exp=2", brStallCnt - br0);
    end
`endif
    cyc();
  endtask

  task automatic test_mdu();
    clear_inputs();
    mduStartE = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL mdu_start_cycle got=%b exp=%b", ctl, CtlIdle);
    end
    cyc();
    mduStartE = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (ctl !== CtlWait) begin
        failures++; $display("FAIL mdu_wait_%0d got=%b exp=%b", i, ctl, CtlWait);
      end
      cyc();
    end
    mduDone = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlDone) begin
      failures++; $display("FAIL mdu_done_cycle got=%b exp=%b", ctl, CtlDone);
    end
    cyc();
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL mdu_back_run got=%b exp=%b", ctl, CtlIdle);
    end
    // Done while in RUN must not start anything.
    cyc();
    mduDone = 1'b0;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL mdu_done_in_run got=%b exp=%b", ctl, CtlIdle);
    end
    cyc();
  endtask

  task automatic test_masking();
    clear_inputs();
    mduStartE = 1'b1;
    cyc();
    // Load-use hazard and a second start while waiting: both ignored.
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    checks++;
    if (ctl !== CtlWait) begin
      failures++; $display("FAIL mask_lw got=%b exp=%b", ctl, CtlWait);
    end
    cyc();
    cyc();
    clear_inputs();
    mduDone = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlDone) begin
      failures++; $display("FAIL mask_done got=%b exp=%b", ctl, CtlDone);
    end
    cyc();
    mduDone = 1'b0;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL mask_start_ignored got=%b exp=%b", ctl, CtlIdle);
    end
    cyc();
  endtask

  task automatic test_timeout();
    int  n;
    bit  found;
`ifdef HAZARD_PERF_EN
    logic [31:0] m0;
    m0 = mduStallCnt;
`endif
    clear_inputs();
    mduStartE = 1'b1;
    cyc();
    mduStartE = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      n++;
      #1;
      if (mduErr) begin
        found = 1'b1;
        checks++;
        if (n !== 16) begin
          failures++; $display("FAIL to_cycle got=%0d exp=16", n);
        end
        checks++;
        if (ctl !== CtlErr) begin
          failures++; $display("FAIL to_err_ctl got=%b exp=%b", ctl, CtlErr);
        end
      end
      cyc();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL to_no_err got=0 exp=1 within 40 cycles");
    end
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL to_back_run got=%b exp=%b", ctl, CtlIdle);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (mduStallCnt - m0 !== 32'd16) begin
      failures++; $display("FAIL to_perf got=%0d exp=16", mduStallCnt - m0);
    end
`endif
    cyc();
  endtask

  task automatic test_done_at_timeout();
    clear_inputs();
    mduStartE = 1'b1;
    cyc();
    mduStartE = 1'b0;
    repeat (15) cyc();
    mduDone = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlDone) begin
      failures++; $display("FAIL done_beats_to got=%b exp=%b", ctl, CtlDone);
    end
    cyc();
    mduDone = 1'b0;
    #1;
    checks++;
    if (ctl !== CtlIdle) begin
      failures++; $display("FAIL done_to_run got=%b exp=%b", ctl, CtlIdle);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mdu();
    test_masking();
    test_timeout();
    test_done_at_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard/sequencing controller for the 5-stage pipeline. It drives stall, flush and forwarding controls for the F/D/E/M stage registers, including the clear input of the ID/EX register.
It detects load-use and branch-operand hazards and holds the pipeline while the multi-cycle mul/div unit (MDU) is busy. An FSM with a timeout watchdog sequences each MDU wait.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before forced abort (>=2)
TO_W, 7, width of wait counter (must hold MDU_TIMEOUT)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
rsD, rtD  in  5  source regs of instruction in D
rsE, rtE  in  5  source regs of instruction in E
writeRegE, writeRegM, writeRegW  in  5  destination reg per stage
regWriteE, regWriteM, regWriteW  in  1  destination write enable per stage
memToRegE, memToRegM  in  1  load in E / M
branchD  in  1  branch/compare instruction in D
mduStartE  in  1  MDU op in E, single-cycle start pulse
mduDone  in  1  MDU result valid, single-cycle pulse
stallF, stallD, stallE  out  1  hold PC, IF/ID, ID/EX
flushE  out  1  drives ID/EX clr (bubble)
flushM  out  1  bubble into EX/MEM
forwardAE, forwardBE  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result
forwardAD, forwardBD  out  1  D branch comparator takes M ALU result
mduBusy  out  1  FSM in MDU_WAIT
mduErr  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst=1): state=RUN, wait counter=0, mduErr=0. All stall/flush/forward outputs are 0 while rst is high.
- Forwarding (combinational, RUN and MDU_WAIT):
  - forwardAE=10 if rsE!=0 && regWriteM && writeRegM==rsE.
  - Else forwardAE=01 if rsE!=0 && regWriteW && writeRegW==rsE.
  - Else forwardAE=00.
  - M has priority over W. Same rules apply to rtE/forwardBE.
  - forwardAD = rsD!=0 && regWriteM && writeRegM==rsD. forwardBD likewise with rtD.
- lwStall = memToRegE && (rtE==rsD || rtE==rtD).
- brStall = branchD && ((regWriteE && (writeRegE==rsD || writeRegE==rtD)) || (memToRegM && (writeRegM==rsD || writeRegM==rtD))).
  - Register 0 never causes brStall.
- FSM states:
  - RUN: stallF=stallD=flushE=(lwStall|brStall). stallE=0, flushM=0.
    - mduStartE=1 -> MDU_WAIT at next edge, counter cleared.
    - Start cycle itself has no MDU stall; the MDU op advances to M as a bubble only via the next state.
  - MDU_WAIT: mduBusy=1, stallF=stallD=stallE=1, flushM=1, flushE=0. Counter increments each cycle.
    - mduDone=1: stalls and flushM deassert combinationally the same cycle; -> RUN at next edge.
    - Counter==MDU_TIMEOUT-1 without done: mduErr=1 for that cycle, stalls released, -> RUN.
    - mduStartE ignored while in MDU_WAIT.
- Simultaneous events:
  - lwStall/brStall during MDU_WAIT are masked; flushE stays 0 because E is held.
  - mduDone and timeout in the same cycle: done wins, mduErr=0.
  - mduDone in RUN is ignored.
- Reset asserted mid-MDU_WAIT: immediate return to RUN, all stalls drop asynchronously.

Optional Feature:
HAZARD_PERF_EN: adds 32-bit output ports lwStallCnt, brStallCnt, mduStallCnt.
- Each increments on cycles where its condition causes a stall: RUN&lwStall, RUN&brStall&!lwStall, MDU_WAIT&!mduDone.
- Counters saturate at 32'hFFFFFFFF and clear on rst.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10, the state encodings ST_RUN/ST_MDU_WAIT and ZERO_WORD.
- One sub-module, fwd_sel: combinational 5-bit compare producing the 2-bit E select. Instantiated for rsE and rtE.

Test Plan:
1. rst=1 mid-MDU_WAIT (counter=10) -> same cycle stall*=0, flushM=0, mduBusy=0; after release, state RUN and counter 0.
2. Forwarding: rsE=3, writeRegM=3, regWriteM=1, writeRegW=3, regWriteW=1 -> forwardAE=10. With writeRegM=0 -> 01. With rsE=0 -> 00.
3. Load-use: memToRegE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for exactly one cycle. Next cycle (load in M) -> no stall, forwardAE=10 is not used for the load (W path gives 01 the following cycle).
4. Branch hazard: branchD=1, rsD=7, regWriteE=1, writeRegE=7 -> one stall cycle. Next cycle with memToRegM=0, writeRegM=7 -> no stall, forwardAD=1.
5. MDU: mduStartE pulse, mduDone 5 cycles later -> mduBusy high 5 cycles, stallE/flushM high 4 cycles and low on the done cycle, back to RUN.
6. Timeout with MDU_TIMEOUT=8, no mduDone -> mduErr pulse on 8th MDU_WAIT cycle, then RUN. With HAZARD_PERF_EN: mduStallCnt=8.
